// File: rtl/spi_master_dual_cs.sv
// -----------------------------------------------------------------------------
// spi_master_dual_cs
//
// SPI master driving two slaves through separate active-low chip selects.
// One WIDTH-bit word is exchanged per accepted start request, MSB first, in
// any of the four CKP/CPH modes. Every SCK half-period lasts DIV clk cycles.
//
// Transfer timeline, relative to the accepting edge E0:
//   E0                    : inputs latched, selected CS low, busy high
//   E0 + k*DIV            : SCK edge k (k = 1..2*WIDTH), odd k = leading
//   E0 + (2*WIDTH+1)*DIV  : CS high, MOSI low, rx_data loaded, done pulse
//
// Parameters
//   WIDTH : bits per transfer (>= 2)
//   DIV   : clk cycles per SCK half-period (>= 1)
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous reset, active low
//   start        : transfer request, honoured only while idle
//   SLAVE_SELECT : 0 = slave 1 (CS1), 1 = slave 2 (CS2)
//   CKP          : SCK idle level
//   CPH          : 0 = sample on leading edge, 1 = sample on trailing edge
//   tx_data      : word to transmit
//   MISO         : serial data from the slaves
//   SCK, MOSI    : registered serial clock and data
//   CS1, CS2     : registered active-low chip selects
//   busy         : high from start acceptance until done
//   done         : one-cycle pulse, rx_data valid
//   rx_data      : last received word, held until the next done or reset
//
// Build option
//   SPI_MASTER_LOOPBACK_EN : when defined, the receive shift register samples
//                            the internal MOSI register instead of MISO, so
//                            every transfer returns rx_data == tx_data.
// -----------------------------------------------------------------------------
module spi_master_dual_cs #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             SLAVE_SELECT,
  input  logic             CKP,
  input  logic             CPH,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             MISO,
  output logic             SCK,
  output logic             MOSI,
  output logic             CS1,
  output logic             CS2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EDGE_W = $clog2(2 * WIDTH + 1);

  // Divider value on the cycle before an SCK edge (or the end of HOLD).
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  // Edges already produced when the final SCK edge is about to happen.
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_TRANSFER,
    ST_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Timing counters
  logic [DIV_W-1:0]  r_div_cnt;
  logic [EDGE_W-1:0] r_edge_cnt;

  // Per-transfer latched configuration and shift registers
  logic              r_cph;
  logic [WIDTH-1:0]  r_tx_sh;
  logic [WIDTH-1:0]  r_rx_sh;

  // Registered outputs
  logic              r_sck;
  logic              r_mosi;
  logic              r_cs1;
  logic              r_cs2;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  r_rx_data;

  // Decoded strobes
  logic w_tick;        // divider has reached the end of a half-period
  logic w_accept;      // start accepted on this edge (E0)
  logic w_sck_edge;    // SCK toggles on this edge
  logic w_leading;     // the pending SCK edge is a leading edge
  logic w_final_edge;  // the pending SCK edge is edge 2*WIDTH
  logic w_mosi_shift;  // MOSI advances to the next bit on this edge
  logic w_rx_sample;   // receive bit captured on this edge
  logic w_finish;      // end of HOLD: release CS and publish rx_data
  logic w_rx_bit;      // serial bit fed into the receive shift register

`ifdef SPI_MASTER_LOOPBACK_EN
  // MOSI already holds the bit belonging to the current sample point.
  assign w_rx_bit = r_mosi;
`else
  assign w_rx_bit = MISO;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked assignment uses <= so all registers update from the
  // values seen before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sck_edge   = 1'b0;
    w_finish     = 1'b0;
    w_mosi_shift = 1'b0;
    w_rx_sample  = 1'b0;
    w_tick       = (r_div_cnt == DIV_LAST);
    // Edge k = r_edge_cnt + 1 is leading when k is odd.
    w_leading    = ~r_edge_cnt[0];
    w_final_edge = (r_edge_cnt == EDGE_LAST);

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          w_sck_edge   = 1'b1;
          w_state_next = ST_TRANSFER;
        end
      end
      ST_TRANSFER: begin
        if (w_tick) begin
          w_sck_edge = 1'b1;
          if (w_final_edge) begin
            w_state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_finish     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_sck_edge) begin
      if (r_cph) begin
        // CPH=1: drive on leading, sample on trailing.
        w_mosi_shift = w_leading;
        w_rx_sample  = ~w_leading;
      end else begin
        // CPH=0: the MSB went out at E0, so drive on every trailing edge
        // except the last; sample on leading.
        w_mosi_shift = ~w_leading & ~w_final_edge;
        w_rx_sample  = w_leading;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Divider and edge counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
    end else if (w_accept) begin
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
    end else if (r_state != ST_IDLE) begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_sck_edge) begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SCK generation
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sck <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      // Tracks CKP while idle, which also sets the idle level at E0.
      r_sck <= CKP;
    end else if (w_sck_edge) begin
      r_sck <= ~r_sck;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cph   <= 1'b0;
      r_tx_sh <= '0;
      r_mosi  <= 1'b0;
    end else if (w_accept) begin
      r_cph <= CPH;
      if (!CPH) begin
        // The MSB must be valid before the first (sampling) leading edge.
        r_mosi  <= tx_data[WIDTH-1];
        r_tx_sh <= tx_data << 1;
      end else begin
        r_tx_sh <= tx_data;
      end
    end else if (w_finish) begin
      r_mosi <= 1'b0;
    end else if (w_mosi_shift) begin
      r_mosi  <= r_tx_sh[WIDTH-1];
      r_tx_sh <= r_tx_sh << 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_sh   <= '0;
      r_rx_data <= '0;
    end else begin
      if (w_accept) begin
        r_rx_sh <= '0;
      end else if (w_rx_sample) begin
        r_rx_sh <= {r_rx_sh[WIDTH-2:0], w_rx_bit};
      end
      // The last sample lands no later than the final SCK edge, DIV cycles
      // before this point, so the shift register is complete here.
      if (w_finish) begin
        r_rx_data <= r_rx_sh;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Chip selects and handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cs1  <= 1'b1;
      r_cs2  <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        // Exactly one select goes low; the other is forced high.
        r_cs1  <= SLAVE_SELECT;
        r_cs2  <= ~SLAVE_SELECT;
        r_busy <= 1'b1;
      end else if (w_finish) begin
        r_cs1  <= 1'b1;
        r_cs2  <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign SCK     = r_sck;
  assign MOSI    = r_mosi;
  assign CS1     = r_cs1;
  assign CS2     = r_cs2;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

endmodule
